bram_responder: RTL and testbench

Single-clock BRAM responder: the memory end of the accelerator's BRAM port (ADDR/WE/EN/DIN/DOUT) used by the CNN datapath for feature, weight and temp buffers. It serves every accelerator request with byte-lane writes and fixed-latency pipelined reads. A secondary host port loads weights and inputs and reads back results, using only the cycles the accelerator leaves idle. It replaces the behavioural `bram` model in layer benches and on the FPGA build.

---
 rtl/bram_pkg.sv | 35 +++
 rtl/bram_rd_pipe.sv | 30 +++
 rtl/bram_responder.sv | 128 ++++++++++++
 tb/tb_bram_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared widths, read-pipe beat format and owner tags for the BRAM responder.
package bram_pkg;

    localparam int DATA_W           = 32;
    localparam int WE_W             = 4;
    localparam int MAX_READ_LATENCY = 4;

    typedef enum logic {
        OWN_ACC  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    typedef struct packed {
        logic              valid;
        owner_e            owner;
        logic [DATA_W-1:0] data;
    } rd_beat_t;

    // Replaces only the byte lanes whose enable bit is set.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] i_old,
        input logic [DATA_W-1:0] i_new,
        input logic [WE_W-1:0]   i_we
    );
        logic [DATA_W-1:0] w_merged;
        w_merged = i_old;
        for (int k = 0; k < WE_W; k++) begin
            if (i_we[k]) begin
                w_merged[8*k +: 8] = i_new[8*k +: 8];
            end
        end
        return w_merged;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Fixed-depth shift register of read beats; the output is the oldest stage.
module bram_rd_pipe
    import bram_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  rd_beat_t i_beat,
    output rd_beat_t o_beat
);

    rd_beat_t r_stage [LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_beat;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_beat = r_stage[LATENCY-1];

endmodule

// File: rtl/bram_responder.sv
// Word-organised BRAM with a never-stalling accelerator port and a host port
// that borrows idle cycles; both share one fixed-latency read pipe.
module bram_responder
    import bram_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic              en,
    input  logic [WE_W-1:0]   wen,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [31:0]       host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              oob_err,
    input  logic              oob_clr
);

    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PIPE_DEPTH = (READ_LATENCY < 1) ? 1 :
                                (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                                READ_LATENCY;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout_hold;
    logic [DATA_W-1:0] r_host_hold;
    logic              r_oob;

    logic [29:0]       w_acc_word;
    logic              w_acc_oob;
    logic              w_host_oob;
    logic [IDX_W-1:0]  w_acc_idx;
    logic [IDX_W-1:0]  w_host_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_rd_oob;
    logic              w_acc_rd;
    logic              w_acc_wr;
    logic              w_host_gnt;
    logic              w_host_rd;
    logic              w_host_wr;
    logic              w_violation;
    logic              w_acc_done;
    logic              w_host_done;
    logic              w_unused;
    rd_beat_t          w_issue;
    rd_beat_t          w_result;

    assign w_acc_word = addr[31:2];
    assign w_unused   = &{1'b0, addr[1:0]};
    assign w_acc_oob  = ({2'b00, w_acc_word} >= 32'(DEPTH));
    assign w_host_oob = (host_addr >= 32'(DEPTH));
    assign w_acc_idx  = w_acc_word[IDX_W-1:0];
    assign w_host_idx = host_addr[IDX_W-1:0];

    // The host only ever sees a grant in cycles the accelerator leaves idle.
    assign w_host_gnt = host_req & ~en & rst;
    assign w_acc_rd   = en & (wen == '0);
    assign w_acc_wr   = en & (wen != '0);
    assign w_host_rd  = w_host_gnt & ~host_we;
    assign w_host_wr  = w_host_gnt & host_we;
    assign host_gnt   = w_host_gnt;

    assign w_rd_idx    = en ? w_acc_idx : w_host_idx;
    assign w_rd_oob    = en ? w_acc_oob : w_host_oob;
    assign w_violation = (en & w_acc_oob) | (w_host_gnt & w_host_oob);

    always_ff @(posedge clk) begin
        if (w_acc_wr && !w_acc_oob) begin
            r_mem[w_acc_idx] <= merge_lanes(r_mem[w_acc_idx], din, wen);
        end else if (w_host_wr && !w_host_oob) begin
            r_mem[w_host_idx] <= host_wdata;
        end
    end

    // Out-of-range reads still travel the pipe so their timing matches a real read.
    always_comb begin
        w_issue       = '0;
        w_issue.valid = w_acc_rd | w_host_rd;
        w_issue.owner = en ? OWN_ACC : OWN_HOST;
        w_issue.data  = w_rd_oob ? '0 : r_mem[w_rd_idx];
    end

    bram_rd_pipe #(
        .LATENCY (PIPE_DEPTH)
    ) u_rd_pipe (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_beat  (w_issue),
        .o_beat  (w_result)
    );

    assign w_acc_done  = w_result.valid & (w_result.owner == OWN_ACC);
    assign w_host_done = w_result.valid & (w_result.owner == OWN_HOST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout_hold <= '0;
            r_host_hold <= '0;
            r_oob       <= 1'b0;
        end else begin
            if (w_acc_done) begin
                r_dout_hold <= w_result.data;
            end
            if (w_host_done) begin
                r_host_hold <= w_result.data;
            end
            if (w_violation) begin
                r_oob <= 1'b1;
            end else if (oob_clr) begin
                r_oob <= 1'b0;
            end
        end
    end

    assign dout        = w_acc_done  ? w_result.data : r_dout_hold;
    assign host_rdata  = w_host_done ? w_result.data : r_host_hold;
    assign host_rvalid = w_host_done;
    assign oob_err     = r_oob;

endmodule

// File: tb/tb_bram_responder.sv
// Drives four responders (READ_LATENCY 1..4) with one shared stimulus stream and
// scores every read result against a memory model through an issue-time queue.
module tb_bram_responder;

    localparam int DEPTH = 1024;
    localparam int NINST = 4;

    typedef struct {
        int          issue;
        logic        host;
        logic [31:0] data;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] din;
    logic        host_req;
    logic        host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic        oob_clr;

    logic [31:0] dout_w   [NINST];
    logic        gnt_w    [NINST];
    logic        rvalid_w [NINST];
    logic [31:0] rdata_w  [NINST];
    logic        oob_w    [NINST];

    int          cyc  = 0;
    int          nvec = 0;
    int          nerr = 0;
    sb_t         sbq[$];
    int          rd_idx   [NINST];
    logic [31:0] exp_dout [NINST];
    logic        exp_oob;
    logic [31:0] model    [DEPTH];
    logic        mon_hv;
    sb_t         mon_e;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        bram_responder #(
            .DEPTH        (DEPTH),
            .READ_LATENCY (g + 1)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .addr        (addr),
            .en          (en),
            .wen         (wen),
            .din         (din),
            .dout        (dout_w[g]),
            .host_req    (host_req),
            .host_we     (host_we),
            .host_addr   (host_addr),
            .host_wdata  (host_wdata),
            .host_gnt    (gnt_w[g]),
            .host_rvalid (rvalid_w[g]),
            .host_rdata  (rdata_w[g]),
            .oob_err     (oob_w[g]),
            .oob_clr     (oob_clr)
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nvec++;
        assert (observed === expected)
        else begin
            nerr++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Result for the read issued in cycle K is due in cycle K+latency of each instance.
    always @(negedge clk) begin
        for (int g = 0; g < NINST; g++) begin
            mon_hv = 1'b0;
            if (rd_idx[g] < sbq.size() && sbq[rd_idx[g]].issue + g + 1 == cyc) begin
                mon_e = sbq[rd_idx[g]];
                rd_idx[g]++;
                if (mon_e.host) begin
                    mon_hv = 1'b1;
                    checkOutput($sformatf("host_rdata L%0d", g + 1), rdata_w[g], mon_e.data);
                end else begin
                    exp_dout[g] = mon_e.data;
                end
            end
            checkOutput($sformatf("dout L%0d", g + 1), dout_w[g], exp_dout[g]);
            checkOutput($sformatf("host_rvalid L%0d", g + 1), {31'b0, rvalid_w[g]}, {31'b0, mon_hv});
        end
    end

    task automatic applyStimulus(
        input logic        i_en,
        input logic [3:0]  i_wen,
        input logic [31:0] i_addr,
        input logic [31:0] i_din,
        input logic        i_hreq,
        input logic        i_hwe,
        input logic [31:0] i_haddr,
        input logic [31:0] i_hwdata,
        input logic        i_clr
    );
        logic [29:0] word;
        logic        viol;
        sb_t         e;
        @(posedge clk);
        #1;
        for (int g = 0; g < NINST; g++) begin
            checkOutput($sformatf("oob_err L%0d", g + 1), {31'b0, oob_w[g]}, {31'b0, exp_oob});
        end
        en         = i_en;
        wen        = i_wen;
        addr       = i_addr;
        din        = i_din;
        host_req   = i_hreq;
        host_we    = i_hwe;
        host_addr  = i_haddr;
        host_wdata = i_hwdata;
        oob_clr    = i_clr;
        #1;
        for (int g = 0; g < NINST; g++) begin
            checkOutput($sformatf("host_gnt L%0d", g + 1), {31'b0, gnt_w[g]}, {31'b0, i_hreq & ~i_en});
        end
        viol = 1'b0;
        if (i_en) begin
            word = i_addr[31:2];
            viol = ({2'b00, word} >= 32'(DEPTH));
            if (i_wen == 4'b0000) begin
                e.issue = cyc; e.host = 1'b0; e.data = viol ? 32'h0 : model[word[9:0]];
                sbq.push_back(e);
            end else if (!viol) begin
                for (int k = 0; k < 4; k++) begin
                    if (i_wen[k]) model[word[9:0]][8*k +: 8] = i_din[8*k +: 8];
                end
            end
        end else if (i_hreq) begin
            viol = (i_haddr >= 32'(DEPTH));
            if (!i_hwe) begin
                e.issue = cyc; e.host = 1'b1; e.data = viol ? 32'h0 : model[i_haddr[9:0]];
                sbq.push_back(e);
            end else if (!viol) begin
                model[i_haddr[9:0]] = i_hwdata;
            end
        end
        if (viol) exp_oob = 1'b1;
        else if (i_clr) exp_oob = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic resetDut();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        en       = 1'b0;
        wen      = 4'h0;
        host_req = 1'b1;
        host_we  = 1'b0;
        oob_clr  = 1'b0;
        for (int g = 0; g < NINST; g++) begin
            rd_idx[g]   = sbq.size();
            exp_dout[g] = 32'h0;
        end
        exp_oob = 1'b0;
        #1;
        for (int g = 0; g < NINST; g++) begin
            checkOutput($sformatf("rst host_gnt L%0d", g + 1), {31'b0, gnt_w[g]}, 32'h0);
            checkOutput($sformatf("rst dout L%0d", g + 1), dout_w[g], 32'h0);
            checkOutput($sformatf("rst host_rvalid L%0d", g + 1), {31'b0, rvalid_w[g]}, 32'h0);
            checkOutput($sformatf("rst host_rdata L%0d", g + 1), rdata_w[g], 32'h0);
            checkOutput($sformatf("rst oob_err L%0d", g + 1), {31'b0, oob_w[g]}, 32'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        host_req = 1'b0;
        rst      = 1'b1;
    endtask

    initial begin
        addr = 0; en = 0; wen = 0; din = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; oob_clr = 0;
        exp_oob = 0;
        for (int g = 0; g < NINST; g++) begin
            rd_idx[g]   = 0;
            exp_dout[g] = 32'h0;
        end
        $display("[TB] start");
        resetDut();

        // Preload words 0..9 and 976 from the host side.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, i, 32'hC0DE0000 + 32'(i) * 32'h00000111, 1'b0);
        end
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'd976, 32'h5A5A0976, 1'b0);

        // Back-to-back accelerator reads of words 0..9.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'h0, 32'(i) * 4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        end
        idleCycles(2);

        // Byte-lane write over a host-written word, then read it back.
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'd5, 32'h11223344, 1'b0);
        applyStimulus(1'b1, 4'b0101, 32'h14, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idleCycles(1);

        // Host read of word 3 held for 6 cycles while the accelerator is busy for 4.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i < 4, 4'h0, 32'(6 + i) * 4, 32'h0, 1'b1, 1'b0, 32'd3, 32'h0, 1'b0);
        end
        idleCycles(1);

        // Read-after-write on consecutive cycles, then back-to-back host reads.
        applyStimulus(1'b1, 4'hF, 32'h1C, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 32'h1C, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, i, 32'h0, 1'b0);
        end
        idleCycles(1);

        // Out-of-range accesses and the sticky error flag.
        applyStimulus(1'b1, 4'h0, 32'h1000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idleCycles(1);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'd2000, 32'hFFFFFFFF, 1'b0);
        applyStimulus(1'b1, 4'hF, 32'h1F40, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, i, 32'h0, 1'b0);
        end
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd976, 32'h0, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 4'h0, 32'h1000, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd5000, 32'h0, 1'b1);
        idleCycles(5);

        // Reset one cycle after a host read: no result may surface.
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd4, 32'h0, 1'b0);
        resetDut();
        idleCycles(5);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd7, 32'h0, 1'b0);
        applyStimulus(1'b1, 4'h0, 32'h14, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idleCycles(6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
